// File: rtl/mac_serial2d_ctrl.sv
// mac_serial2d_ctrl
// Sequencer for the 2D 4-bit-serial MAC. It runs one dot-product job of
// num_acc multiply-accumulates and emits a registered per-cycle control word
// for the serial multiplier. It also generates the accumulator enable,
// handshakes operand pairs with the upstream buffer, and flags completion.
//
// Ports
//   clk_fast  : single clock for the sequencer and the datapath
//   rst       : synchronous active-high reset
//   start     : job request, sampled only while idle
//   mode      : precision (000 = 8x8, 001 = 8bW x 4bA, 111 = 4x4)
//   num_acc   : number of products in the job (0 allowed)
//   op_valid  : upstream w/a pair valid
//   op_ready  : pair consumed this cycle (transfer = op_valid & op_ready)
//   mode_q    : latched job mode, used by the datapath clock gating
//   w_sel, a_sel, sign_ctr, shift_ctr, rst_mult : registered control word
//   acc_en    : accumulator (slow clock) enable
//   busy      : job in progress, through the done cycle
//   done      : one-cycle pulse, accumulator holds the final result
//   cfg_err   : one-cycle pulse, start rejected because of an illegal mode
module mac_serial2d_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk_fast,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] num_acc,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [2:0]       mode_q,
  output logic             w_sel,
  output logic             a_sel,
  output logic             sign_ctr,
  output logic             shift_ctr,
  output logic             rst_mult,
  output logic             acc_en,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_COMMIT = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Control word packing: {w_sel, a_sel, sign_ctr, shift_ctr, rst_mult}
  localparam logic [4:0]       WORD_NOP    = 5'b00000;
  localparam logic [4:0]       WORD_COMMIT = 5'b00001;
  localparam logic [CNT_W-1:0] PROD_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PROD_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [1:0]       step_q;
  logic [CNT_W-1:0] prod_q;
  logic             pending_q;
  logic [2:0]       mode_lat_q;
  logic [4:0]       word_q;
  logic             acc_word_q;
  logic             acc_en_q;
  logic             op_ready_q;
  logic             busy_q;
  logic             done_word_q;
  logic             done_q;
  logic             cfg_err_q;

  logic [1:0]       last_step_s;
  logic [1:0]       step_d;
  logic [CNT_W-1:0] prod_d;

  function automatic logic mode_legal(input logic [2:0] m);
    case (m)
      3'b000, 3'b001, 3'b111: mode_legal = 1'b1;
      default:                mode_legal = 1'b0;
    endcase
  endfunction

  // Index of the last step of a product (steps per product minus one).
  function automatic logic [1:0] last_step(input logic [2:0] m);
    case (m)
      3'b000:  last_step = 2'd3;
      3'b001:  last_step = 2'd1;
      default: last_step = 2'd0;
    endcase
  endfunction

  // Per-step control word; rst_mult is set on s0 so each product restarts.
  function automatic logic [4:0] ctrl_word(input logic [2:0] m, input logic [1:0] s);
    case ({m, s})
      5'b000_00: ctrl_word = 5'b00011;
      5'b000_01: ctrl_word = 5'b01000;
      5'b000_10: ctrl_word = 5'b10110;
      5'b000_11: ctrl_word = 5'b11100;
      5'b001_00: ctrl_word = 5'b00011;
      5'b001_01: ctrl_word = 5'b10100;
      5'b111_00: ctrl_word = 5'b00101;
      default:   ctrl_word = 5'b00000;
    endcase
  endfunction

  assign last_step_s = last_step(mode_lat_q);
  assign step_d      = step_q + 2'd1;
  assign prod_d      = prod_q - PROD_ONE;

  // Job sequencer: state, counters and every registered output.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= 2'd0;
      prod_q      <= PROD_ZERO;
      pending_q   <= 1'b0;
      mode_lat_q  <= 3'b000;
      word_q      <= WORD_NOP;
      acc_word_q  <= 1'b0;
      acc_en_q    <= 1'b0;
      op_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_word_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      // Defaults: NOP word, pulses low. acc_en and done trail their
      // control-word fields by one cycle to line up with the wrapper's
      // input-register stage, so z is final while done is high.
      word_q      <= WORD_NOP;
      acc_word_q  <= 1'b0;
      acc_en_q    <= acc_word_q;
      op_ready_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      done_word_q <= 1'b0;
      done_q      <= done_word_q;
      if (done_q) begin
        busy_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          // busy_q still covers the done cycle, so a start there is ignored.
          if (start && !busy_q) begin
            if (mode_legal(mode)) begin
              mode_lat_q <= mode;
              prod_q     <= num_acc;
              busy_q     <= 1'b1;
              state_q    <= S_CLEAR;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          // acc_en with rst_mult low loads zero into the accumulator.
          acc_word_q <= 1'b1;
          step_q     <= 2'd0;
          pending_q  <= 1'b0;
          if (prod_q == PROD_ZERO) begin
            state_q <= S_DONE;
          end else begin
            state_q    <= S_RUN;
            op_ready_q <= (last_step_s == 2'd0);
          end
        end

        S_RUN: begin
          if ((step_q == 2'd0) && !op_valid) begin
            // Upstream stalled: flush the finished product before waiting.
            state_q <= pending_q ? S_COMMIT : S_WAIT;
          end else if (step_q == last_step_s) begin
            if (op_valid) begin
              word_q     <= ctrl_word(mode_lat_q, step_q);
              // With one step per product s0 is also the last step, so it
              // must still add the previous product.
              acc_word_q <= (step_q == 2'd0) ? pending_q : 1'b0;
              pending_q  <= 1'b1;
              prod_q     <= prod_d;
              step_q     <= 2'd0;
              if (prod_q == PROD_ONE) begin
                state_q <= S_COMMIT;
              end else begin
                op_ready_q <= (last_step_s == 2'd0);
              end
            end else begin
              // Protocol violation (valid dropped mid-product): hold.
              op_ready_q <= 1'b1;
            end
          end else begin
            word_q     <= ctrl_word(mode_lat_q, step_q);
            acc_word_q <= (step_q == 2'd0) ? pending_q : 1'b0;
            step_q     <= step_d;
            op_ready_q <= (step_d == last_step_s);
          end
        end

        S_COMMIT: begin
          word_q     <= WORD_COMMIT;
          acc_word_q <= 1'b1;
          pending_q  <= 1'b0;
          state_q    <= (prod_q == PROD_ZERO) ? S_DONE : S_WAIT;
        end

        S_WAIT: begin
          if (op_valid) begin
            state_q    <= S_RUN;
            step_q     <= 2'd0;
            op_ready_q <= (last_step_s == 2'd0);
          end
        end

        S_DONE: begin
          done_word_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign {w_sel, a_sel, sign_ctr, shift_ctr, rst_mult} = word_q;
  assign op_ready = op_ready_q;
  assign mode_q   = mode_lat_q;
  assign acc_en   = acc_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;

endmodule
